// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, access sizes, FSM states and widths shared by the
// load/store unit and its lane sub-module.
package lsu_pkg;

    localparam int XLEN  = 32;
    localparam int OFF_W = 2;

    // RV32I load encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // RV32I store encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Access size carried in funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_e;

    // True when funct3 names an access this unit implements.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational little-endian lane logic. Extracts and extends the
// addressed byte/halfword of a loaded word, and splices a store's byte/halfword
// into the old memory word (the memory has no byte enables).
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0]  word,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_data,
    output logic [XLEN-1:0]  store_word
);

    logic [4:0]        shamt;
    logic [XLEN-1:0]   lane;
    logic [XLEN-1:0]   mask;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    // Byte offset into bit shift; offsets are already naturally aligned.
    assign shamt  = {off, 3'b000};
    assign lane   = word >> shamt;
    assign lane_b = lane[7:0];
    assign lane_h = lane[15:0];

    // Pick the load lane and sign- or zero-extend it to a full word
    always_comb begin
        load_data = '0;
        case (funct3)
            LB:      load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
            LH:      load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
            LW:      load_data = word;
            LBU:     load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
            LHU:     load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: load_data = '0;
        endcase
    end

    // Merge the store lane into the old word; full-word stores pass straight through
    always_comb begin
        mask = '1;
        case (funct3[1:0])
            SZ_BYTE: mask = {{(XLEN-8){1'b0}}, 8'hFF};
            SZ_HALF: mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            default: mask = '1;
        endcase
        store_word = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
    end

endmodule

// File: rtl/lsu_core.sv
// lsu_core: single-outstanding load/store unit in front of a word-wide data
// memory with one write enable. Sub-word stores are done as read-modify-write.
// Optional feature: define LSU_MISALIGN_TRAP_EN to report misaligned halfword /
// word accesses as errors; otherwise their low address bits are forced to
// natural alignment and the access proceeds.
module lsu_core
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out
);

    lsu_state_e        state;
    logic [1:0]        size;
    logic [OFF_W-1:0]  eff_off;
    logic              acc_err;
    logic              accept;

    logic [2:0]        cap_f3;
    logic [OFF_W-1:0]  cap_off;
    logic [DATA_W-1:0] cap_wdata;

    logic [DATA_W-1:0] lane_rdata;
    logic [DATA_W-1:0] lane_wword;

    assign size   = req_funct3[1:0];
    assign accept = (state == IDLE) && req_valid;

    // Lane offset actually used: halfword/word offsets rounded down to natural alignment
    always_comb begin
        eff_off = req_addr[1:0];
        case (size)
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            SZ_WORD: eff_off = 2'b00;
            default: eff_off = req_addr[1:0];
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    assign misal   = ((size == SZ_HALF) && req_addr[0]) ||
                     ((size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign acc_err = !f3_legal(req_store, req_funct3) || misal;
`else
    assign acc_err = !f3_legal(req_store, req_funct3);
`endif

    // Hold the request fields the later states need; data only, no reset required
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_f3    <= req_funct3;
            cap_off   <= eff_off;
            cap_wdata <= req_wdata;
        end
    end

    lsu_lane u_lane (
        .word       (mem_data_out),
        .off        (cap_off),
        .funct3     (cap_f3),
        .wdata      (cap_wdata),
        .load_data  (lane_rdata),
        .store_word (lane_wword)
    );

    // Request FSM with all handshake and memory-port outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        mem_addr   <= {2'b00, req_addr[ADDR_W-1:2]};
                        resp_rdata <= '0;
                        resp_err   <= acc_err;
                        if (acc_err) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (!req_store) begin
                            state <= LOAD;
                        end else if (size == SZ_WORD) begin
                            mem_data_in  <= req_wdata;
                            mem_write_en <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= lane_rdata;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    mem_data_in  <= lane_wword;
                    mem_write_en <= 1'b1;
                    state        <= WRITE;
                end
                WRITE: begin
                    mem_write_en <= 1'b0;
                    resp_valid   <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready    <= 1'b1;
                    resp_valid   <= 1'b0;
                    mem_write_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_core.sv
// tb_lsu_core: randomized bench for lsu_core against a byte-arithmetic
// reference model and a 16-word memory array.
module tb_lsu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_write_en;
    logic [31:0] mem_data_out;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    lsu_core #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT, plus a preload port for the bench
    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (mem_write_en)
            mem[mem_addr[3:0]] <= mem_data_in;
    end

    assign mem_data_out = mem[mem_addr[3:0]];

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] last_rd;
    logic        last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic load_word(input int idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx[3:0];
        pl_val = val;
        @(posedge clk); #1;
        pl_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One full transaction: model prediction, drive, observe, optional stall, handshake
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall);
        int          nb, a, off, idx, lat, exp_lat, wc, exp_wc, t;
        logic        legal, misal, exp_err;
        logic [31:0] mask, old, v, exp_rd, new_w, wa, wv;

        legal = st ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a     = int'(addr);
        misal = (a % nb) != 0;
        exp_err = !legal || (TRAP && misal);
        a     = a - (a % nb);
        idx   = a / 4;
        off   = a % 4;
        mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        old   = ref_mem[idx];
        exp_rd = '0;
        new_w  = old;
        exp_wc = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!st) begin
            v = (old >> (8 * off)) & mask;
            if (!f3[2] && nb < 4 && v[8 * nb - 1])
                v = v | ~mask;
            exp_rd  = v;
            exp_lat = 2;
        end else begin
            new_w   = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            exp_lat = (nb == 4) ? 2 : 3;
            exp_wc  = 1;
            ref_mem[idx] = new_w;
        end

        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready)
            check("req_ready_timeout", {31'b0, req_ready}, 32'd1);

        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        check("busy_req_ready", {31'b0, req_ready}, 32'd0);

        lat = 1;
        wc  = 0;
        wa  = '0;
        wv  = '0;
        while (!resp_valid && lat < 8) begin
            if (mem_write_en) begin
                wc++;
                wa = mem_addr;
                wv = mem_data_in;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_valid", {31'b0, resp_valid}, 32'd1);
        check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        check("resp_rdata", resp_rdata, exp_rd);
        check("we_in_resp", {31'b0, mem_write_en}, 32'd0);
        check("we_pulses", 32'(wc), 32'(exp_wc));
        if (wc > 0) begin
            check("write_addr", wa, 32'(idx));
            check("write_data", wv, new_w);
        end
        last_rd  = resp_rdata;
        last_err = resp_err;

        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("stall_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, exp_rd);
            check("stall_err", {31'b0, resp_err}, {31'b0, exp_err});
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post_hs_valid", {31'b0, resp_valid}, 32'd0);
        check("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
        if (exp_wc > 0)
            check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int t;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data_in", mem_data_in, 32'd0);
        check("rst_mem_we", {31'b0, mem_write_en}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++)
            load_word(i, $urandom());

        // Directed cases from the block's feature list
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        check("tp_sw_mem", mem[4], 32'hDEAD_BEEF);

        load_word(4, 32'h8081_F0F1);
        do_req(1'b0, 3'b000, 32'h13, '0, 0);
        check("tp_lb", last_rd, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h13, '0, 0);
        check("tp_lbu", last_rd, 32'h0000_0080);
        do_req(1'b0, 3'b001, 32'h10, '0, 0);
        check("tp_lh", last_rd, 32'hFFFF_F0F1);
        do_req(1'b0, 3'b101, 32'h12, '0, 0);
        check("tp_lhu", last_rd, 32'h0000_8081);
        do_req(1'b0, 3'b010, 32'h10, '0, 0);
        check("tp_lw", last_rd, 32'h8081_F0F1);

        load_word(4, 32'h1122_3344);
        do_req(1'b1, 3'b000, 32'h11, 32'h0000_00AA, 0);
        check("tp_sb_mem", mem[4], 32'h1122_AA44);

        load_word(4, 32'h8081_F0F1);
        do_req(1'b0, 3'b010, 32'h12, '0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("tp_lw_misal_err", {31'b0, last_err}, 32'd1);
`else
        check("tp_lw_misal_data", last_rd, 32'h8081_F0F1);
`endif

        // Response stall followed by an immediate back-to-back request
        do_req(1'b0, 3'b010, 32'h10, '0, 5);
        do_req(1'b0, 3'b001, 32'h12, '0, 0);
        check("tp_b2b_lh", last_rd, 32'hFFFF_8081);

        // Reset during the write cycle of a halfword store
        load_word(4, 32'h1122_3344);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h12;
        req_wdata  = 32'h0000_5566;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (!mem_write_en && t < 8) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_we_seen", {31'b0, mem_write_en}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_we_drop", {31'b0, mem_write_en}, 32'd0);
        check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", {31'b0, req_ready}, 32'd1);
        check("rel_resp_valid", {31'b0, resp_valid}, 32'd0);
        load_word(4, 32'h1122_3344);
        do_req(1'b0, 3'b011, 32'h10, '0, 0);
        check("tp_illegal_f3_err", {31'b0, last_err}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 63)), $urandom(), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_core.md
# lsu_core

Load/store unit sitting between the execute stage and the data memory. Accepts one load or store request at a time and drives the data memory's word-wide, single-write-enable port (addr, data_in, write_en, data_out). Performs little-endian byte/halfword lane selection, sign/zero extension on loads, and read-modify-write for sub-word stores, since the memory has no byte enables. Returns each result through a valid/ready response channel.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; fixed at 32.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I size/sign encoding.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_err`  out  1  misaligned access or illegal funct3.
- `mem_addr`  out  32  word address to memory (`req_addr[31:2]`).
- `mem_data_in`  out  32  write data to memory.
- `mem_write_en`  out  1  memory write strobe.
- `mem_data_out`  in  32  memory read data, combinational on `mem_addr`.

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, capture the request at the clock edge. Next state:
  - error → RESP
  - load → LOAD
  - SW → WRITE
  - SB/SH → RMW_RD
- LOAD: drive `mem_addr`, register the extracted/extended lane → RESP.
- RMW_RD: drive `mem_addr`, register `mem_data_out` merged with the new byte/half lane → WRITE.
- WRITE: `mem_write_en`=1 for exactly this cycle; `mem_addr` and `mem_data_in` stay stable → RESP.
- RESP: `resp_valid`=1 and outputs held stable until `resp_ready`, then → IDLE.
- Loads:
  - LB/LBU select lane `addr[1:0]`; LH/LHU select lane `addr[1]`; LW takes the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Legal funct3:
  - loads: 000, 001, 010, 100, 101
  - stores: 000, 001, 010
  - any other value sets `resp_err`.
- Misalignment is a halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0. Handling depends on the macro (see Configuration).
- An erroring request never asserts `mem_write_en`, and its `resp_rdata` is 0.
- `mem_write_en` is 0 in every state except WRITE.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_addr`=0, `mem_data_in`=0, `mem_write_en`=0.
- Latency, counted from the accept edge to the first cycle `resp_valid`=1:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- Throughput: one request in flight. `req_ready`=0 outside IDLE.
- Back-to-back: a request is accepted in the cycle after the RESP handshake, never in the same cycle.
- `resp_ready` held low keeps RESP and all response outputs frozen indefinitely.
- `req_valid` while busy is ignored. The requester holds it until `req_ready`.
- Reset asserted mid-operation returns to IDLE immediately. If it hits during WRITE, `mem_write_en` drops asynchronously; the write may or may not land.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses set `resp_err`, skip memory, and go IDLE → RESP.
- Not defined: misaligned accesses are not errors. Low address bits are forced down to natural alignment (half: `addr[0]`=0; word: `addr[1:0]`=0) and the access proceeds normally. Illegal funct3 still errors.

## Structure
- Package `lsu_pkg`:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW
  - state enum
  - width constants
- Sub-module `lsu_lane`, combinational:
  - load lane extract/extend (word, addr[1:0], funct3 → rdata)
  - store merge (old word, wdata, addr[1:0], funct3 → new word)
- `lsu_core` holds the FSM and registers.

## Test plan
- Reset then SW addr 0x10 data 0xDEADBEEF → `mem_write_en` high exactly 1 cycle with `mem_addr`=0x4 and `mem_data_in`=0xDEADBEEF; `resp_valid` 2 cycles after accept with `resp_err`=0.
- Memory word 0x4 = 0x8081F0F1:
  - LB 0x13 → 0xFFFFFF80
  - LBU 0x13 → 0x00000080
  - LH 0x10 → 0xFFFFF0F1
  - LHU 0x12 → 0x00008081
  - LW 0x10 → 0x8081F0F1
- Memory word 0x4 = 0x11223344, SB 0x11 data 0xAA → RMW_RD then WRITE; memory becomes 0x1122AA44; `resp_valid` 3 cycles after accept.
- LW addr 0x12:
  - with `LSU_MISALIGN_TRAP_EN` → `resp_err`=1, `mem_write_en` never rises, latency 1.
  - without the macro → reads word 0x4.
- `resp_ready` held low for 5 cycles after a load → `resp_valid` and `resp_rdata` stable throughout, `req_ready`=0; the next request is accepted the cycle after the handshake.
- Assert `reset` during WRITE of an SH → `mem_write_en` falls immediately; after release, `req_ready`=1 and `resp_valid`=0; funct3 011 load → `resp_err`=1.
